// File: rtl/core_seq.sv
// core_seq: attention-score row sequencer. Each Q row is dotted with COL K
// vectors, one column per cycle, and the finished row is handed out through a
// valid/ready slot. Q/K memories are loaded only while idle.
// Optional feature: define CORE_SEQ_SUM_EN to add the sum_out port, which holds
// the sum of |psum| over the columns of the current output row.
module core_seq #(
    parameter int BW      = 8,
    parameter int PR      = 16,
    parameter int COL     = 8,
    parameter int DEPTH   = 16,
    parameter int BW_PSUM = 2*BW+4,
    parameter int CORE_ID = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [$clog2(DEPTH):0]     n_rows,
    input  logic                       mem_wr,
    input  logic                       mem_sel,
    input  logic [$clog2(DEPTH)-1:0]   mem_addr,
    input  logic [PR*BW-1:0]           mem_in,
    output logic                       busy,
    output logic                       done,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [BW_PSUM*COL-1:0]     out,
`ifdef CORE_SEQ_SUM_EN
    output logic [BW_PSUM+3:0]         sum_out,
`endif
    output logic [$clog2(DEPTH)-1:0]   out_row
);

    localparam int AW = $clog2(DEPTH);
    localparam int NW = AW + 1;
    localparam int CW = (COL > 1) ? $clog2(COL) : 1;
    localparam logic [CW-1:0] LAST_COL = CW'(COL - 1);

    // Reject configurations the datapath cannot represent.
    if ((DEPTH < COL) || ((DEPTH & (DEPTH - 1)) != 0) ||
        (BW_PSUM < 2*BW + $clog2(PR)) || (CORE_ID < 0)) begin : g_bad_param
        $error("core_seq: illegal parameter set");
    end

    typedef enum logic [1:0] {IDLE, RUN, WAIT_OUT} state_t;

    state_t                    state;
    logic [AW-1:0]             row;
    logic [CW-1:0]             col;
    logic [AW-1:0]             n_last;
    logic [BW_PSUM*COL-1:0]    row_buf;

    logic [PR*BW-1:0]          q_mem [DEPTH];
    logic [PR*BW-1:0]          k_mem [DEPTH];

    logic [PR*BW-1:0]          q_vec;
    logic [PR*BW-1:0]          k_vec;
    logic signed [2*BW-1:0]    prod;
    logic signed [BW_PSUM-1:0] psum;
    logic [BW_PSUM*COL-1:0]    next_row;
    logic                      slot_free;

    // Memory load port, only honoured while idle.
    // NOTE: storage arrays carry no reset; their contents must survive a reset.
    always_ff @(posedge clk) begin
        if (mem_wr && state == IDLE) begin
            if (mem_sel) k_mem[mem_addr] <= mem_in;
            else         q_mem[mem_addr] <= mem_in;
        end
    end

    assign q_vec     = q_mem[row];
    assign k_vec     = k_mem[AW'(col)];
    assign slot_free = !out_valid || out_ready;

    // Signed dot product of the current Q row and K column over all lanes.
    // NOTE: every variable assigned here gets a default first, so no latch is inferred.
    always_comb begin
        prod = '0;
        psum = '0;
        for (int p = 0; p < PR; p++) begin
            prod = $signed(q_vec[p*BW +: BW]) * $signed(k_vec[p*BW +: BW]);
            psum = psum + BW_PSUM'(prod);
        end
    end

    // Completed row as it will look once the current column is merged in.
    always_comb begin
        next_row = row_buf;
        next_row[col*BW_PSUM +: BW_PSUM] = psum;
    end

`ifdef CORE_SEQ_SUM_EN
    logic [BW_PSUM+3:0] next_sum;
    logic [BW_PSUM-1:0] col_mag;

    // Sum of column magnitudes for the row about to be loaded.
    always_comb begin
        next_sum = '0;
        col_mag  = '0;
        for (int j = 0; j < COL; j++) begin
            col_mag = next_row[j*BW_PSUM +: BW_PSUM];
            if (col_mag[BW_PSUM-1]) col_mag = -col_mag;
            next_sum = next_sum + {4'b0000, col_mag};
        end
    end
`endif

    // Control FSM with registered status and output slot.
    // NOTE: state registers use non-blocking assignments so every read sees the pre-edge value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            row       <= '0;
            col       <= '0;
            n_last    <= '0;
            row_buf   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out       <= '0;
            out_row   <= '0;
`ifdef CORE_SEQ_SUM_EN
            sum_out   <= '0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (n_rows == '0) begin
                            done <= 1'b1;
                        end else begin
                            row    <= '0;
                            col    <= '0;
                            busy   <= 1'b1;
                            state  <= RUN;
                            n_last <= (n_rows > NW'(DEPTH)) ? AW'(DEPTH - 1)
                                                            : AW'(n_rows - NW'(1));
                        end
                    end
                end
                RUN: begin
                    if (out_valid && out_ready) out_valid <= 1'b0;
                    if (col != LAST_COL) begin
                        row_buf[col*BW_PSUM +: BW_PSUM] <= psum;
                        col <= col + CW'(1);
                    end else if (slot_free) begin
                        row_buf   <= next_row;
                        out       <= next_row;
                        out_row   <= row;
                        out_valid <= 1'b1;
`ifdef CORE_SEQ_SUM_EN
                        sum_out   <= next_sum;
`endif
                        col <= '0;
                        if (row == n_last) state <= WAIT_OUT;
                        else               row   <= row + AW'(1);
                    end
                end
                WAIT_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_core_seq.sv
// Scoreboard bench for core_seq: stimulus pushes expected rows, a monitor pops
// and compares on every accepted output row.
module tb_core_seq;

    localparam int BW = 8, PR = 16, COL = 8, DEPTH = 16, BWP = 20;
    localparam int RW = BWP * COL;

    typedef struct {
        logic [3:0]    row;
        logic [RW-1:0] data;
        logic [23:0]   sum;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            start = 1'b0;
    logic [4:0]      n_rows = '0;
    logic            mem_wr = 1'b0;
    logic            mem_sel = 1'b0;
    logic [3:0]      mem_addr = '0;
    logic [PR*BW-1:0] mem_in = '0;
    logic            busy, done, out_valid;
    logic            out_ready = 1'b0;
    logic [RW-1:0]   out;
    logic [3:0]      out_row;
`ifdef CORE_SEQ_SUM_EN
    logic [23:0]     sum_out;
`endif

    int   pass_cnt = 0;
    int   total_cnt = 0;
    exp_t sb[$];
    exp_t mon_e;

    core_seq dut (
        .clk(clk), .reset(reset), .start(start), .n_rows(n_rows),
        .mem_wr(mem_wr), .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_in(mem_in),
        .busy(busy), .done(done), .out_valid(out_valid), .out_ready(out_ready),
        .out(out),
`ifdef CORE_SEQ_SUM_EN
        .sum_out(sum_out),
`endif
        .out_row(out_row)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [PR*BW-1:0] lanes_all(input int v);
        logic [PR*BW-1:0] r;
        for (int p = 0; p < PR; p++) r[p*BW +: BW] = 8'(v);
        return r;
    endfunction

    function automatic logic [PR*BW-1:0] lanes_alt();
        logic [PR*BW-1:0] r;
        for (int p = 0; p < PR; p++) r[p*BW +: BW] = (p % 2 == 0) ? 8'h01 : 8'hFF;
        return r;
    endfunction

    // Column j = PR*qv*j, for K[j] filled with j in every lane.
    function automatic logic [RW-1:0] exp_uniform(input int qv);
        logic [RW-1:0] r;
        for (int j = 0; j < COL; j++) r[j*BWP +: BWP] = 20'(PR * qv * j);
        return r;
    endfunction

    function automatic logic [RW-1:0] exp_const(input int v);
        logic [RW-1:0] r;
        for (int j = 0; j < COL; j++) r[j*BWP +: BWP] = 20'(v);
        return r;
    endfunction

    function automatic logic [23:0] abs_sum(input logic [RW-1:0] d);
        int s = 0;
        int v;
        for (int j = 0; j < COL; j++) begin
            v = int'($signed(d[j*BWP +: BWP]));
            s += (v < 0) ? -v : v;
        end
        return 24'(s);
    endfunction

    task automatic push_exp(input int row, input logic [RW-1:0] d);
        exp_t e;
        e.row = 4'(row);
        e.data = d;
        e.sum = abs_sum(d);
        sb.push_back(e);
    endtask

    task automatic mem_write(input bit sel, input int addr, input logic [PR*BW-1:0] d);
        mem_wr = 1'b1; mem_sel = sel; mem_addr = 4'(addr); mem_in = d;
        @(posedge clk); #1;
        mem_wr = 1'b0;
    endtask

    task automatic start_run(input int n);
        start = 1'b1; n_rows = 5'(n);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Waits for done (want_done=1) or out_valid; an expired budget is a failure.
    task automatic wait_sig(input bit want_done, input int limit, output int cycles);
        cycles = 0;
        do begin
            @(posedge clk); #1;
            cycles++;
        end while (!(want_done ? done : out_valid) && cycles < limit);
        if (!(want_done ? done : out_valid))
            check(want_done ? "done_timeout" : "valid_timeout", 0, 1);
    endtask

    // Monitor: each accepted row is compared against the head of the scoreboard.
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_row: got row %0d data %h, expected none", out_row, out);
            end else begin
                mon_e = sb.pop_front();
                check("out_row", 256'(out_row), 256'(mon_e.row));
                check("out_data", 256'(out), 256'(mon_e.data));
`ifdef CORE_SEQ_SUM_EN
                check("sum_out", 256'(sum_out), 256'(mon_e.sum));
`endif
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int vcount;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 256'(out_valid), 0);
        check("rst_busy", 256'(busy), 0);
        check("rst_done", 256'(done), 0);
        check("rst_out", 256'(out), 0);
        check("rst_out_row", 256'(out_row), 0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Basic run: Q[0]=1, K[j]=j -> column j = 16*j
        mem_write(1'b0, 0, lanes_all(1));
        for (int j = 0; j < COL; j++) mem_write(1'b1, j, lanes_all(j));
        out_ready = 1'b1;
        push_exp(0, exp_uniform(1));
        start_run(1);
        check("busy_running", 256'(busy), 1);
        wait_sig(1'b0, 50, cyc);
        check("first_valid_latency", 256'(cyc), 8);
        wait_sig(1'b1, 50, cyc);
        check("done_after_handshake", 256'(cyc), 1);
        @(posedge clk); #1;
        check("done_one_cycle", 256'(done), 0);
        check("idle_busy", 256'(busy), 0);

        // Extreme operands: -128 * -128 over 16 lanes
        mem_write(1'b0, 0, lanes_all(-128));
        for (int j = 0; j < COL; j++) mem_write(1'b1, j, lanes_all(-128));
        push_exp(0, exp_const(262144));
        start_run(1);
        wait_sig(1'b1, 100, cyc);

        // Backpressure across three rows
        for (int j = 0; j < COL; j++) mem_write(1'b1, j, lanes_all(j));
        mem_write(1'b0, 0, lanes_all(1));
        mem_write(1'b0, 1, lanes_all(2));
        mem_write(1'b0, 2, lanes_all(-1));
        push_exp(0, exp_uniform(1));
        push_exp(1, exp_uniform(2));
        push_exp(2, exp_uniform(-1));
        out_ready = 1'b0;
        start_run(3);
        repeat (20) @(posedge clk);
        #1;
        check("stall_valid", 256'(out_valid), 1);
        check("stall_row", 256'(out_row), 0);
        check("stall_data", 256'(out), 256'(exp_uniform(1)));
        check("stall_busy", 256'(busy), 1);
        out_ready = 1'b1;
        wait_sig(1'b1, 100, cyc);
        check("stall_drained", 256'(sb.size()), 0);

        // Asynchronous reset in the middle of a run
        start_run(1);
        repeat (4) @(posedge clk);
        #1;
        check("pre_reset_busy", 256'(busy), 1);
        reset = 1'b0;
        #1;
        check("mid_rst_valid", 256'(out_valid), 0);
        check("mid_rst_busy", 256'(busy), 0);
        check("mid_rst_done", 256'(done), 0);
        check("mid_rst_out", 256'(out), 0);
        #2 reset = 1'b1;
        @(posedge clk); #1;
        push_exp(0, exp_uniform(1));
        start_run(1);
        wait_sig(1'b1, 100, cyc);

        // Zero-row start: done only, no output
        start_run(0);
        check("zero_rows_done", 256'(done), 1);
        check("zero_rows_busy", 256'(busy), 0);
        vcount = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_valid) vcount++;
        end
        check("zero_rows_no_valid", 256'(vcount), 0);

        // Writes and start while busy are ignored
        push_exp(0, exp_uniform(1));
        start_run(1);
        mem_wr = 1'b1; mem_sel = 1'b1; mem_addr = 4'd3; mem_in = lanes_all(5);
        start = 1'b1; n_rows = 5'd3;
        @(posedge clk); #1;
        mem_sel = 1'b0; mem_addr = 4'd0; mem_in = lanes_all(7);
        @(posedge clk); #1;
        mem_wr = 1'b0; start = 1'b0;
        wait_sig(1'b1, 100, cyc);
        push_exp(0, exp_uniform(1));
        start_run(1);
        wait_sig(1'b1, 100, cyc);
        check("busy_writes_drained", 256'(sb.size()), 0);

        // n_rows above DEPTH clamps to DEPTH rows
        for (int r = 0; r < DEPTH; r++) begin
            mem_write(1'b0, r, lanes_all(r - 8));
            push_exp(r, exp_uniform(r - 8));
        end
        start_run(20);
        wait_sig(1'b1, 400, cyc);
        @(posedge clk); #1;
        check("clamp_drained", 256'(sb.size()), 0);

        // Alternating-sign lanes: cancelling and reinforcing patterns
        mem_write(1'b0, 0, lanes_alt());
        for (int j = 0; j < COL; j++) mem_write(1'b1, j, lanes_all(1));
        push_exp(0, exp_const(0));
        start_run(1);
        wait_sig(1'b1, 100, cyc);
        for (int j = 0; j < COL; j++) mem_write(1'b1, j, lanes_alt());
        push_exp(0, exp_const(16));
        start_run(1);
        wait_sig(1'b1, 100, cyc);

        repeat (3) @(posedge clk);
        check("final_drained", 256'(sb.size()), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/core_seq.md
CORE_SEQ -- requirements
Module: core_seq

Interface
REQ-001 Parameters SHALL be: BW=8 (operand bits); PR=16 (lanes per vector); COL=8 (K vectors per row); DEPTH=16 (Q/K entries, power of 2, DEPTH>=COL); BW_PSUM=2*BW+4 (psum bits, SHALL be >= 2*BW+clog2(PR)); CORE_ID=0.
REQ-002 clk  in  1  the single clock; all state changes on its rising edge.
REQ-003 reset  in  1  asynchronous, active-low.
REQ-004 start  in  1  one-cycle pulse; begins a run; sampled only in IDLE.
REQ-005 n_rows  in  clog2(DEPTH)+1  number of Q rows to process; sampled with start.
REQ-006 mem_wr  in  1  write mem_in into the memory selected by mem_sel at mem_addr.
REQ-007 mem_sel  in  1  0 = Q memory, 1 = K memory.
REQ-008 mem_addr  in  clog2(DEPTH)  write address.
REQ-009 mem_in  in  PR*BW  packed signed vector; lane p is bits [p*BW +: BW].
REQ-010 busy  out  1  high in RUN and WAIT_OUT.
REQ-011 done  out  1  one-cycle pulse at run completion.
REQ-012 out_valid  out  1  out, out_row (and sum_out) hold a valid row.
REQ-013 out_ready  in  1  consumer accepts the row when out_valid&&out_ready.
REQ-014 out  out  BW_PSUM*COL  row psums; column j is bits [j*BW_PSUM +: BW_PSUM], signed.
REQ-015 out_row  out  clog2(DEPTH)  Q row index of the current out.

Function
REQ-016 The FSM SHALL have exactly IDLE, RUN, WAIT_OUT.
REQ-017 In IDLE, mem_wr SHALL write the selected memory on the same edge; mem_wr in RUN/WAIT_OUT SHALL be ignored.
REQ-018 In IDLE, start with n_rows>0 SHALL clear row=0 and col=0 and enter RUN; start with n_rows==0 SHALL pulse done next cycle and stay IDLE.
REQ-019 Each RUN cycle SHALL compute psum = signed sum over p of Q[row].lane[p]*K[col].lane[p], sign-extended to BW_PSUM, and register it into row-buffer column col.
REQ-020 col SHALL increment each RUN cycle, wrapping COL-1 -> 0 with row increment.
REQ-021 On the cycle col==COL-1, if the output slot is free (!out_valid or out_ready), the completed row SHALL load into out/out_row and out_valid SHALL be set; otherwise the FSM SHALL stall, holding row/col, until the slot frees.
REQ-022 First out_valid SHALL rise exactly COL cycles after the start edge when unstalled; throughput SHALL be one row per COL cycles.
REQ-023 Loading the last row (row==n_rows-1) SHALL move the FSM to WAIT_OUT.
REQ-024 In WAIT_OUT, the handshake of the last row SHALL clear out_valid, pulse done, and return to IDLE in the same edge.
REQ-025 out_valid SHALL clear on handshake unless a new row loads on that edge; out/out_row SHALL be stable while out_valid&&!out_ready.
REQ-026 start during busy SHALL be ignored.
REQ-027 n_rows>DEPTH SHALL be clamped to DEPTH.

Reset
REQ-028 reset low SHALL asynchronously force IDLE, row=col=0, busy=0, done=0, out_valid=0, out=0, out_row=0 (and sum_out=0), including mid-run.
REQ-029 Q/K memory contents SHALL NOT be reset.

Configuration
REQ-030 With CORE_SEQ_SUM_EN defined, output port sum_out (BW_PSUM+4 bits, unsigned) SHALL carry the sum of |psum| over the COL columns of out, valid and stable with out_valid; without it, the port and its logic SHALL be absent and all other behaviour SHALL be unchanged.

Verification
REQ-031 Q[0] all lanes 1, K[j] all lanes j, n_rows=1, out_ready=1 -> out column j = 16*j, out_valid at start+8, done one cycle after handshake.
REQ-032 Q and K all lanes -128, n_rows=1 -> every column = 262144 (0x40000), no overflow at BW_PSUM=20.
REQ-033 n_rows=3, out_ready held low 20 cycles -> row 0 held stable, engine stalls at col=7 of row 1, rows 0,1,2 delivered in order once ready rises, no loss or duplication.
REQ-034 reset asserted at RUN cycle 4 -> out_valid, busy, done low immediately; a new start after release reproduces correct results from the retained memory contents.
REQ-035 start with n_rows=0 -> done pulse next cycle, out_valid never rises; mem_wr and start during busy -> memory unchanged, run unaffected.
REQ-036 With CORE_SEQ_SUM_EN, Q[0] lanes alternating +1/-1, K[j] all lanes 1 -> every column 0, sum_out=0; K[j] lanes alternating +1/-1 -> columns 16, sum_out=128.
